// File: rtl/mclr5_lsu_sequencer.sv
// Issues the memory ops of one four-slot bundle one at a time, in slot order,
// on the single data-memory port. The core is stalled until the bundle completes.
module mclr5_lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned TIMEOUT_W      = 4
) (
    input  logic         CORE_CLK,
    input  logic         RST,
    input  logic         BUNDLE_VALID,
    input  logic [3:0]   SLOT_EN,
    input  logic [3:0]   SLOT_LOAD_REQ,
    input  logic [3:0]   SLOT_STORE_REQ,
    input  logic [127:0] SLOT_ADDR,
    input  logic [127:0] SLOT_WDATA,
    output logic [31:0]  MEM_ADDR,
    output logic [31:0]  MEM_WDATA,
    output logic         MEM_LOAD_REQ,
    output logic         MEM_STORE_REQ,
    input  logic         MEM_ACK,
    input  logic [31:0]  MEM_RDATA,
    output logic         STALL,
    output logic         BUNDLE_DONE,
    output logic [3:0]   LOAD_VALID,
    output logic [127:0] LOAD_DATA,
    output logic         ERR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [TIMEOUT_W-1:0] TMO_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [1:0]           state_q, state_d;
    logic [3:0]           mask_q, mask_d;
    logic [3:0]           store_q, store_d;
    logic [3:0][31:0]     addr_q, addr_d;
    logic [3:0][31:0]     wdata_q, wdata_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 tmo_q, tmo_d;
    logic [3:0]           lv_q, lv_d;
    logic [3:0][31:0]     ld_q, ld_d;

    logic [3:0]           pending;
    logic [1:0]           cur_idx;
    logic                 in_req;
    logic                 cur_store;
    logic [3:0]           mask_clr;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign pending = SLOT_EN & (SLOT_LOAD_REQ | SLOT_STORE_REQ);
    assign in_req  = (state_q == S_REQ);

    // Lowest set mask bit is the oldest unissued slot.
    always_comb begin
        cur_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i]) cur_idx = 2'(i);
        end
    end

    assign cur_store = store_q[cur_idx];
    assign mask_clr  = mask_q & ~(4'b0001 << cur_idx);
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        store_d = store_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        lv_d    = lv_q;
        ld_d    = ld_q;
        case (state_q)
            S_IDLE: begin
                if (BUNDLE_VALID && (|pending)) begin
                    mask_d  = pending;
                    store_d = SLOT_STORE_REQ & pending;
                    addr_d  = SLOT_ADDR;
                    wdata_d = SLOT_WDATA;
                    lv_d    = '0;
                    ld_d    = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the limit cycle wins over the timeout.
                if (MEM_ACK) begin
                    mask_d = mask_clr;
                    cnt_d  = '0;
                    if (!cur_store) begin
                        lv_d[cur_idx] = 1'b1;
                        ld_d[cur_idx] = MEM_RDATA;
                    end
                    if (mask_clr == 4'b0000) state_d = S_DONE;
                end else if (cnt_inc == TMO_LIM) begin
                    mask_d  = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                tmo_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CORE_CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            store_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            lv_q    <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            lv_q    <= lv_d;
            ld_q    <= ld_d;
        end
    end

    assign STALL         = in_req | ((state_q == S_IDLE) & BUNDLE_VALID & (|pending));
    assign MEM_LOAD_REQ  = in_req & ~cur_store;
    assign MEM_STORE_REQ = in_req & cur_store;
    assign MEM_ADDR      = in_req ? addr_q[cur_idx] : 32'h0;
    assign MEM_WDATA     = (in_req && cur_store) ? wdata_q[cur_idx] : 32'h0;
    assign BUNDLE_DONE   = (state_q == S_DONE);
    assign ERR           = (state_q == S_DONE) & tmo_q;
    assign LOAD_VALID    = lv_q;
    assign LOAD_DATA     = ld_q;

endmodule

// File: tb/tb_mclr5_lsu_sequencer.sv
// Bench for mclr5_lsu_sequencer: table of bundles driven against a memory
// responder with per-slot ack delays, plus hand sequences for reset and idle.
module tb_mclr5_lsu_sequencer;

    localparam int TMO = 15;

    logic         CORE_CLK = 1'b0;
    logic         RST;
    logic         BUNDLE_VALID;
    logic [3:0]   SLOT_EN, SLOT_LOAD_REQ, SLOT_STORE_REQ;
    logic [127:0] SLOT_ADDR, SLOT_WDATA;
    logic [31:0]  MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic         MEM_LOAD_REQ, MEM_STORE_REQ, MEM_ACK;
    logic         STALL, BUNDLE_DONE, ERR;
    logic [3:0]   LOAD_VALID;
    logic [127:0] LOAD_DATA;

    mclr5_lsu_sequencer #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(4)) dut (
        .CORE_CLK(CORE_CLK), .RST(RST), .BUNDLE_VALID(BUNDLE_VALID),
        .SLOT_EN(SLOT_EN), .SLOT_LOAD_REQ(SLOT_LOAD_REQ), .SLOT_STORE_REQ(SLOT_STORE_REQ),
        .SLOT_ADDR(SLOT_ADDR), .SLOT_WDATA(SLOT_WDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_LOAD_REQ(MEM_LOAD_REQ), .MEM_STORE_REQ(MEM_STORE_REQ),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .STALL(STALL), .BUNDLE_DONE(BUNDLE_DONE),
        .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .ERR(ERR)
    );

    always #5 CORE_CLK = ~CORE_CLK;

    typedef struct {
        logic [3:0]       en, ld, st;
        logic [3:0][31:0] addr, wdata;
        logic [31:0]      rbase;
        logic [3:0][7:0]  dly;
        int               exp_cyc;
        logic [3:0]       exp_lv;
        logic             exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        st;
    } mreq_t;

    vec_t  tv[7];
    mreq_t sb[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        BUNDLE_VALID   = 1'b0;
        SLOT_EN        = '0;
        SLOT_LOAD_REQ  = '0;
        SLOT_STORE_REQ = '0;
        SLOT_ADDR      = '0;
        SLOT_WDATA     = '0;
        MEM_ACK        = 1'b0;
        MEM_RDATA      = '0;
    endtask

    // Called at a negedge; returns at the negedge after the DONE cycle.
    task automatic run_vec(input vec_t v, input string nm);
        logic [3:0]       pend;
        logic [3:0][31:0] eld;
        int               slots[4];
        int               nslot, k, w, reqc;
        bit               stop, done;
        mreq_t            e, m;
        pend = v.en & (v.ld | v.st);
        eld = '0; nslot = 0; stop = 0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            if (pend[i] && !stop) begin
                slots[nslot] = i; nslot++;
                if (int'(v.dly[i]) >= TMO) stop = 1;
                else begin
                    e.addr = v.addr[i]; e.st = v.st[i];
                    e.wdata = v.st[i] ? v.wdata[i] : 32'h0;
                    sb.push_back(e);
                    if (!v.st[i]) eld[i] = v.rbase ^ v.addr[i];
                end
            end
        end
        BUNDLE_VALID = 1'b1; SLOT_EN = v.en; SLOT_LOAD_REQ = v.ld; SLOT_STORE_REQ = v.st;
        SLOT_ADDR = v.addr; SLOT_WDATA = v.wdata; MEM_ACK = 1'b0;
        #1 chk({nm, "_stall_accept"}, 128'(STALL), 128'(1));
        k = 0; w = 0; reqc = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge CORE_CLK);
            if (BUNDLE_DONE) begin
                done = 1;
                MEM_ACK = 1'b0;
                BUNDLE_VALID = 1'b0;
                chk({nm, "_err"}, 128'(ERR), 128'(v.exp_err));
                chk({nm, "_stall_done"}, 128'(STALL), 128'(0));
                chk({nm, "_req_done"}, 128'({MEM_LOAD_REQ, MEM_STORE_REQ}), 128'(0));
            end else begin
                reqc++;
                if (STALL !== 1'b1) chk({nm, "_stall_req"}, 128'(STALL), 128'(1));
                if ((MEM_LOAD_REQ ^ MEM_STORE_REQ) !== 1'b1 || k >= nslot) begin
                    chk({nm, "_onehot_req"}, 128'({MEM_LOAD_REQ, MEM_STORE_REQ}), 128'(k < nslot ? 1 : 0));
                    MEM_ACK = 1'b0;
                end else if (w >= int'(v.dly[slots[k]])) begin
                    MEM_ACK = 1'b1;
                    MEM_RDATA = v.rbase ^ MEM_ADDR;
                    if (sb.size() == 0) chk({nm, "_sb_empty"}, 128'(0), 128'(1));
                    else begin
                        m = sb.pop_front();
                        chk({nm, "_addr"}, 128'(MEM_ADDR), 128'(m.addr));
                        chk({nm, "_wdata"}, 128'(MEM_WDATA), 128'(m.wdata));
                        chk({nm, "_is_store"}, 128'({MEM_STORE_REQ, MEM_LOAD_REQ}), 128'({m.st, ~m.st}));
                    end
                    w = 0; k++;
                end else begin
                    MEM_ACK = 1'b0;
                    w++;
                end
            end
        end
        if (!done) begin
            chk({nm, "_done_seen"}, 128'(0), 128'(1));
            idle_inputs();
        end
        chk({nm, "_req_cycles"}, 128'(reqc), 128'(v.exp_cyc));
        chk({nm, "_sb_left"}, 128'(sb.size()), 128'(0));
        chk({nm, "_load_valid"}, 128'(LOAD_VALID), 128'(v.exp_lv));
        chk({nm, "_load_data"}, LOAD_DATA, eld);
        @(negedge CORE_CLK);
        chk({nm, "_done_pulse"}, 128'({BUNDLE_DONE, ERR}), 128'(0));
        chk({nm, "_lv_hold"}, 128'(LOAD_VALID), 128'(v.exp_lv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{en:4'b0100, ld:4'b0100, st:4'b0000,
                  addr:{32'h0, 32'h100, 32'h0, 32'h0}, wdata:'0, rbase:32'hDEADBFEF,
                  dly:{8'd0, 8'd1, 8'd0, 8'd0}, exp_cyc:2, exp_lv:4'b0100, exp_err:1'b0};
        tv[1] = '{en:4'b1111, ld:4'b1001, st:4'b0110,
                  addr:{32'hC, 32'h8, 32'h4, 32'h0},
                  wdata:{32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_00AA},
                  rbase:32'hA5A5_0000, dly:'0, exp_cyc:4, exp_lv:4'b1001, exp_err:1'b0};
        tv[2] = '{en:4'b0011, ld:4'b1111, st:4'b0000,
                  addr:{32'h40, 32'h30, 32'h20, 32'h10}, wdata:'0, rbase:32'h1234_0000,
                  dly:'0, exp_cyc:2, exp_lv:4'b0011, exp_err:1'b0};
        tv[3] = '{en:4'b0010, ld:4'b0010, st:4'b0010,
                  addr:{32'h0, 32'h0, 32'h200, 32'h0}, wdata:{32'h0, 32'h0, 32'h55, 32'h0},
                  rbase:32'h0F0F_0000, dly:'0, exp_cyc:1, exp_lv:4'b0000, exp_err:1'b0};
        tv[4] = '{en:4'b0011, ld:4'b0011, st:4'b0000,
                  addr:{32'h0, 32'h0, 32'h304, 32'h300}, wdata:'0, rbase:32'h0,
                  dly:{8'd0, 8'd0, 8'd255, 8'd255}, exp_cyc:15, exp_lv:4'b0000, exp_err:1'b1};
        tv[5] = '{en:4'b0001, ld:4'b0001, st:4'b0000,
                  addr:{32'h0, 32'h0, 32'h0, 32'h400}, wdata:'0, rbase:32'h7777_0000,
                  dly:{8'd0, 8'd0, 8'd0, 8'd14}, exp_cyc:15, exp_lv:4'b0001, exp_err:1'b0};
        tv[6] = '{en:4'b1111, ld:4'b1111, st:4'b0000,
                  addr:{32'h50C, 32'h508, 32'h504, 32'h500}, wdata:'0, rbase:32'hC0DE_0000,
                  dly:{8'd1, 8'd2, 8'd0, 8'd3}, exp_cyc:10, exp_lv:4'b1111, exp_err:1'b0};

        idle_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CORE_CLK);
        @(negedge CORE_CLK);
        chk("reset_outputs",
            128'({STALL, BUNDLE_DONE, ERR, MEM_LOAD_REQ, MEM_STORE_REQ, LOAD_VALID, MEM_ADDR, MEM_WDATA}), 128'(0));
        chk("reset_load_data", LOAD_DATA, 128'(0));
        RST = 1'b0;
        @(negedge CORE_CLK);

        for (int i = 0; i < 7; i++) begin
            run_vec(tv[i], $sformatf("v%0d", i));
            if (i == 0) chk("v0_deadbeef", 128'(LOAD_DATA[95:64]), 128'(32'hDEADBEEF));
        end

        // Empty bundle with a stray ack: nothing starts and load results hold.
        BUNDLE_VALID = 1'b1; SLOT_EN = 4'b1111; SLOT_LOAD_REQ = '0; SLOT_STORE_REQ = '0;
        MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;
        #1 chk("empty_stall", 128'(STALL), 128'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge CORE_CLK);
            chk("empty_quiet", 128'({STALL, BUNDLE_DONE, MEM_LOAD_REQ, MEM_STORE_REQ, LOAD_VALID}), 128'(5'b0_0_0_0 << 4 | 4'b1111));
        end
        idle_inputs();
        @(negedge CORE_CLK);

        // Reset during the second REQ cycle of a 3-slot bundle.
        BUNDLE_VALID = 1'b1; SLOT_EN = 4'b0111; SLOT_LOAD_REQ = 4'b0111;
        SLOT_ADDR = {32'h0, 32'h28, 32'h24, 32'h20}; MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
        @(negedge CORE_CLK);
        chk("rst_req1_addr", 128'(MEM_ADDR), 128'(32'h20));
        @(negedge CORE_CLK);
        chk("rst_req2_addr", 128'(MEM_ADDR), 128'(32'h24));
        RST = 1'b1; BUNDLE_VALID = 1'b0; MEM_ACK = 1'b0;
        @(negedge CORE_CLK);
        chk("rst_mid_outputs",
            128'({STALL, BUNDLE_DONE, ERR, MEM_LOAD_REQ, MEM_STORE_REQ, LOAD_VALID, MEM_ADDR}), 128'(0));
        chk("rst_mid_load_data", LOAD_DATA, 128'(0));
        RST = 1'b0;
        idle_inputs();
        @(negedge CORE_CLK);
        chk("rst_no_done", 128'({BUNDLE_DONE, STALL, MEM_LOAD_REQ}), 128'(0));
        run_vec(tv[1], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mclr5_lsu_sequencer.md
Name: mclr5_lsu_sequencer

Overview:
Serialises the load/store operations of one four-slot issue bundle onto the single data-memory port of the quad-issue RISC-V core. The core presents all four slots' requests at once. This block holds the core with STALL, then issues the requests one at a time in program order with a valid/ack handshake, and returns per-slot load data. It sits between the four ALU slots and the LOAD_STORE_ADDRESS/STORE_DATA/LOAD_DATA memory interface.

Parameters:
TIMEOUT_CYCLES, 15, max cycles a request waits for MEM_ACK before being abandoned (1..2^TIMEOUT_W-1)
TIMEOUT_W, 4, width of the wait counter

Ports:
CORE_CLK  input  1  core clock; all state updates on rising edge
RST  input  1  reset, synchronous, active-high
BUNDLE_VALID  input  1  slot request inputs are valid this cycle
SLOT_EN  input  4  slot i still live (not squashed by an earlier taken branch)
SLOT_LOAD_REQ  input  4  slot i wants a load
SLOT_STORE_REQ  input  4  slot i wants a store
SLOT_ADDR  input  128  slot i address at [32i+31:32i]
SLOT_WDATA  input  128  slot i store data at [32i+31:32i]
MEM_ADDR  output  32  memory address
MEM_WDATA  output  32  memory store data
MEM_LOAD_REQ  output  1  load request, held until acked
MEM_STORE_REQ  output  1  store request, held until acked
MEM_ACK  input  1  memory accepted/completed the current request
MEM_RDATA  input  32  load data, valid with MEM_ACK
STALL  output  1  core must hold PC and bundle
BUNDLE_DONE  output  1  one-cycle pulse: bundle memory ops complete
LOAD_VALID  output  4  slot i load data valid
LOAD_DATA  output  128  slot i load result at [32i+31:32i]
ERR  output  1  one-cycle pulse with BUNDLE_DONE when a timeout occurred

Behaviour:
- Reset (RST=1 at an edge): state IDLE; mask, counter and captures cleared. All outputs 0 (STALL=0, MEM_*_REQ=0, LOAD_VALID=0, LOAD_DATA=0, ERR=0). Reset mid-transfer drops the in-flight request with no completion.
- pending[i] = SLOT_EN[i] & (SLOT_LOAD_REQ[i] | SLOT_STORE_REQ[i]). If both load and store are set on a slot, it is issued as a store.
- STALL is combinational: 1 when state==REQ, or when state==IDLE & BUNDLE_VALID & |pending. It is 0 in DONE.
- IDLE: on BUNDLE_VALID & |pending:
  - latch pending into mask, latch per-slot op type, SLOT_ADDR and SLOT_WDATA;
  - clear LOAD_VALID and LOAD_DATA;
  - go to REQ.
  Bundles with no pending slot are ignored; no STALL, no DONE.
- REQ:
  - Current slot = lowest set bit of mask (slot 0 first). MEM_ADDR/MEM_WDATA come from registered copies and stay stable while the request is held.
  - Exactly one of MEM_LOAD_REQ/MEM_STORE_REQ is 1. MEM_WDATA is 0 for loads.
  - On MEM_ACK=1: clear the slot's mask bit. For a load, capture MEM_RDATA into LOAD_DATA[slot] and set LOAD_VALID[slot]. Reset the wait counter.
  - If mask is non-zero after the clear, the next slot's request is presented the very next cycle (back-to-back, no bubble). If mask becomes 0, go to DONE.
- Timeout: the counter increments each REQ cycle without MEM_ACK. When it equals TIMEOUT_CYCLES without ack:
  - drop the request;
  - clear mask, so remaining slots are abandoned with LOAD_VALID=0;
  - set a timeout flag and go to DONE.
  An ack in the same cycle the counter hits the limit counts as success.
- DONE, one cycle: BUNDLE_DONE=1, ERR=timeout flag (then cleared), MEM_*_REQ=0, STALL=0. BUNDLE_VALID is ignored here because it is still the completed bundle. Next state IDLE.
- LOAD_VALID/LOAD_DATA hold from DONE until the next accepted bundle.
- MEM_ACK in IDLE or DONE is ignored.
- Latency: a bundle with N pending slots and ack delays d_k (d_k ≥ 0 extra cycles, ack may arrive in the first REQ cycle) takes N + Σd_k REQ cycles plus 1 DONE cycle.

Test Plan:
- Single load on slot 2, addr 0x100, MEM_ACK one cycle after request with RDATA 0xDEADBEEF -> STALL high 2 cycles; MEM_ADDR=0x100, MEM_LOAD_REQ=1; then BUNDLE_DONE pulse, LOAD_VALID=4'b0100, LOAD_DATA[95:64]=0xDEADBEEF.
- All four slots (loads on 0 and 3, stores on 1 and 2, addrs 0x0/0x4/0x8/0xC), MEM_ACK tied 1 -> four consecutive REQ cycles with addrs 0x0, 0x4, 0x8, 0xC in order; store cycles show the matching WDATA; DONE on cycle 5; LOAD_VALID=4'b1001.
- SLOT_EN=4'b0011 with requests on all slots -> only slots 0 and 1 are issued; slots 2 and 3 are never presented.
- Slot 1 with both load and store set, WDATA 0x55 -> MEM_STORE_REQ=1, MEM_LOAD_REQ=0, LOAD_VALID[1]=0.
- Slots 0 and 1 pending, MEM_ACK never asserted, TIMEOUT_CYCLES=15 -> request held 15 cycles, then DONE with ERR=1, LOAD_VALID=0; slot 1 never issued.
- RST=1 asserted during the second REQ cycle of a 3-slot bundle -> next cycle all outputs 0, state IDLE; a fresh bundle then completes normally.
